gain_corrector_pipe: RTL



---
 rtl/gain_corr_pkg.sv | 45 ++++
 rtl/gain_corr_cal_table.sv | 47 ++++
 rtl/gain_corrector_pipe.sv | 132 +++++++++++++
 3 files changed

// File: rtl/gain_corr_pkg.sv
// Shared types and arithmetic helpers for the
// pipelined multi-channel gain corrector.
package gain_corr_pkg;

  localparam int DW   = 8;
  localparam int NCH  = 4;
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int FRAC = DW - 1;
  localparam int CW   = 16;

  typedef struct packed {
    logic [CHW-1:0]  ch;
    logic [2*DW-1:0] data;
    logic            sat;
  } stage_t;

  function automatic logic [DW-1:0] unity_gain();
    return {{(DW-1){1'b0}}, 1'b1} << FRAC;
  endfunction

  // {sat, value}: clamp a signed DW+2 bit sum to 0..2^DW-1
  function automatic logic [DW:0] clamp_sum(
    input logic [DW+1:0] s
  );
    if (s[DW+1])
      return {1'b1, {DW{1'b0}}};
    else if (s[DW])
      return {1'b1, {DW{1'b1}}};
    else
      return {1'b0, s[DW-1:0]};
  endfunction

  // {sat, value}: drop gain fraction, clamp to DW bits
  function automatic logic [DW:0] clamp_prod(
    input logic [2*DW-1:0] p
  );
    logic [2*DW-1:0] q;
    q = p >> FRAC;
    if (|q[2*DW-1:DW])
      return {1'b1, {DW{1'b1}}};
    else
      return {1'b0, q[DW-1:0]};
  endfunction

endpackage

// File: rtl/gain_corr_cal_table.sv
// Per-channel offset/gain register file.
// Sync write, combinational read, unity defaults.
module gain_corr_cal_table
  import gain_corr_pkg::*;
#(
  parameter int NUM_CH = NCH,
  parameter int CH_W   = CHW,
  parameter int DATA_W = DW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_i,
  input  logic [CH_W-1:0]   wr_ch_i,
  input  logic [DATA_W-1:0] wr_off_i,
  input  logic [DATA_W-1:0] wr_gain_i,
  input  logic [CH_W-1:0]   rd_ch_i,
  output logic [DATA_W-1:0] rd_off_o,
  output logic [DATA_W-1:0] rd_gain_o
);

  logic [DATA_W-1:0] off_q  [NUM_CH];
  logic [DATA_W-1:0] gain_q [NUM_CH];

  // Table storage; unknown channels never written
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        off_q[i]  <= '0;
        gain_q[i] <= unity_gain();
      end
    end else if (wr_i && int'(wr_ch_i) < NUM_CH) begin
      off_q[wr_ch_i]  <= wr_off_i;
      gain_q[wr_ch_i] <= wr_gain_i;
    end
  end

  // Read port; unknown channels get identity coefs
  always_comb begin
    rd_off_o  = '0;
    rd_gain_o = unity_gain();
    if (int'(rd_ch_i) < NUM_CH) begin
      rd_off_o  = off_q[rd_ch_i];
      rd_gain_o = gain_q[rd_ch_i];
    end
  end

endmodule

// File: rtl/gain_corrector_pipe.sv
// Three-stage offset/gain corrector with
// valid/ready handshake and saturation counter.
module gain_corrector_pipe
  import gain_corr_pkg::*;
#(
  parameter int DATA_W    = DW,
  parameter int NUM_CH    = NCH,
  parameter int CH_W      = CHW,
  parameter int GAIN_FRAC = FRAC,
  parameter int CNT_W     = CW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cal_wr,
  input  logic [CH_W-1:0]   cal_ch,
  input  logic [DATA_W-1:0] cal_offset,
  input  logic [DATA_W-1:0] cal_gain,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] in_raw,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [CH_W-1:0]   out_ch,
  output logic [DATA_W-1:0] out_corr,
  output logic              out_sat,
  output logic [CNT_W-1:0]  sat_cnt,
  input  logic              sat_clr
);

  logic              en;
  logic              acc;
  logic [DATA_W-1:0] off_rd;
  logic [DATA_W-1:0] gain_rd;
  logic [DATA_W+1:0] sum;

  stage_t            s1_d, s1_q;
  stage_t            s2_d, s2_q;
  logic              s1_vld_q, s2_vld_q;
  logic [DATA_W-1:0] s1_gain_q;

  logic              out_vld_q;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic [DATA_W-1:0] out_corr_q, out_corr_d;
  logic              out_sat_q, out_sat_d;
  logic              gsat;
  logic [CNT_W-1:0]  sat_cnt_q, sat_cnt_d;

  assign en     = ~out_vld_q | out_rdy;
  assign in_rdy = en;
  assign acc    = in_vld & en;

  gain_corr_cal_table #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W),
    .DATA_W (DATA_W)
  ) u_tab (
    .clk       (clk),
    .rst       (rst),
    .wr_i      (cal_wr),
    .wr_ch_i   (cal_ch),
    .wr_off_i  (cal_offset),
    .wr_gain_i (cal_gain),
    .rd_ch_i   (in_ch),
    .rd_off_o  (off_rd),
    .rd_gain_o (gain_rd)
  );

  // Stage math: S1 offset clamp, S2 multiply, S3 gain clamp
  always_comb begin
    sum = {2'b00, in_raw}
        + {{2{off_rd[DATA_W-1]}}, off_rd};
    s1_d    = '0;
    s1_d.ch = in_ch;
    {s1_d.sat, s1_d.data[DATA_W-1:0]} = clamp_sum(sum);
    s2_d      = '0;
    s2_d.ch   = s1_q.ch;
    s2_d.sat  = s1_q.sat;
    s2_d.data = s1_q.data * {{DATA_W{1'b0}}, s1_gain_q};
    {gsat, out_corr_d} = clamp_prod(s2_q.data);
    out_ch_d  = s2_q.ch;
    out_sat_d = s2_q.sat | gsat;
  end

  // Lock-step pipeline registers; all hold on stall
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q   <= 1'b0;
      s1_q       <= '0;
      s1_gain_q  <= '0;
      s2_vld_q   <= 1'b0;
      s2_q       <= '0;
      out_vld_q  <= 1'b0;
      out_ch_q   <= '0;
      out_corr_q <= '0;
      out_sat_q  <= 1'b0;
    end else if (en) begin
      s1_vld_q   <= acc;
      s1_q       <= s1_d;
      s1_gain_q  <= gain_rd;
      s2_vld_q   <= s1_vld_q;
      s2_q       <= s2_d;
      out_vld_q  <= s2_vld_q;
      out_ch_q   <= out_ch_d;
      out_corr_q <= out_corr_d;
      out_sat_q  <= out_sat_d;
    end
  end

  // Sticky counter: clear wins, stops at all-ones
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (sat_clr)
      sat_cnt_d = '0;
    else if (out_vld_q && out_rdy && out_sat_q
             && !(&sat_cnt_q))
      sat_cnt_d = sat_cnt_q + 1'b1;
  end

  // Saturation counter register
  always_ff @(posedge clk) begin
    if (rst) sat_cnt_q <= '0;
    else     sat_cnt_q <= sat_cnt_d;
  end

  assign out_vld  = out_vld_q;
  assign out_ch   = out_ch_q;
  assign out_corr = out_corr_q;
  assign out_sat  = out_sat_q;
  assign sat_cnt  = sat_cnt_q;

endmodule
